// File: rtl/multi_button_debounce.sv
// N-channel button debouncer: 2-flop synchroniser plus stability counter per channel,
// registered level and one-cycle press/release strobes. Define DEBOUNCE_AUTOREPEAT_EN for auto-repeat.
module multi_button_debounce #(
   parameter int unsigned N_CH          = 5,
   parameter int unsigned STABLE_CYCLES = 5000000,
   parameter int unsigned REPEAT_DELAY  = 50000000,
   parameter int unsigned REPEAT_PERIOD = 10000000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_press,
   output logic [N_CH-1:0] btn_release
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYCLES - 1);

   if (N_CH < 1 || STABLE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("multi_button_debounce: all parameters must be >= 1");
   end

   logic [N_CH-1:0] s1;
   logic [N_CH-1:0] s2;
   logic [N_CH-1:0] accept;
   logic [CW-1:0]   cnt [N_CH];

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RP_TERM = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0]   rcnt [N_CH];
   logic [N_CH-1:0] rfirst;
`endif

   always_comb begin
      accept = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         accept[i] = (s2[i] != btn_level[i]) && (cnt[i] == CNT_TERM);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1          <= '0;
         s2          <= '0;
         btn_level   <= '0;
         btn_press   <= '0;
         btn_release <= '0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            cnt[i] <= '0;
         end
`ifdef DEBOUNCE_AUTOREPEAT_EN
         rfirst <= '1;
         for (int unsigned i = 0; i < N_CH; i++) begin
            rcnt[i] <= '0;
         end
`endif
      end else begin
         s1 <= btn_in;
         s2 <= s1;
         for (int unsigned i = 0; i < N_CH; i++) begin
            btn_press[i]   <= accept[i] & s2[i];
            btn_release[i] <= accept[i] & ~s2[i];
            if (s2[i] == btn_level[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               btn_level[i] <= s2[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
`ifdef DEBOUNCE_AUTOREPEAT_EN
            // Accepting edge (press or release) restarts the delay phase and outranks a repeat.
            if (!btn_level[i] || accept[i]) begin
               rcnt[i]   <= '0;
               rfirst[i] <= 1'b1;
            end else if (rcnt[i] == (rfirst[i] ? RD_TERM : RP_TERM)) begin
               rcnt[i]      <= '0;
               rfirst[i]    <= 1'b0;
               btn_press[i] <= 1'b1;
            end else begin
               rcnt[i] <= rcnt[i] + RW'(1);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_multi_button_debounce.sv
// Self-checking bench for multi_button_debounce (N_CH=2, STABLE_CYCLES=4): directed step table,
// auto-repeat sequence when DEBOUNCE_AUTOREPEAT_EN is defined, and random stimulus against a window model.
module tb_multi_button_debounce;

   localparam int S  = 4;
   localparam int RD = 8;
   localparam int RP = 3;
`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic [1:0] btn;
   logic [1:0] btn_level;
   logic [1:0] btn_press;
   logic [1:0] btn_release;

   int checks = 0;
   int errors = 0;

   multi_button_debounce #(
      .N_CH(2),
      .STABLE_CYCLES(S),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clk),
      .reset(rst),
      .btn_in(btn),
      .btn_level(btn_level),
      .btn_press(btn_press),
      .btn_release(btn_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: level/press/release got %b expected %b", name, act, exp);
      end
   endtask

   // Reference model: a channel flips when the last S synchronised samples (input seen
   // two edges earlier and before) all differ from the current level.
   logic [1:0] hist [0:S];
   logic [1:0] m_lvl;
   logic [1:0] m_prs;
   logic [1:0] m_rel;
   int         m_age [2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= S; j++) hist[j] = 2'b00;
         m_lvl = 2'b00;
         m_prs = 2'b00;
         m_rel = 2'b00;
         m_age[0] = 0;
         m_age[1] = 0;
      end else begin
         m_prs = 2'b00;
         m_rel = 2'b00;
         for (int c = 0; c < 2; c++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 1; j <= S; j++) if (hist[j][c] == m_lvl[c]) all_diff = 1'b0;
            if (all_diff) begin
               if (!m_lvl[c]) begin
                  m_prs[c] = 1'b1;
                  m_age[c] = 0;
               end else begin
                  m_rel[c] = 1'b1;
               end
               m_lvl[c] = ~m_lvl[c];
            end else if (AR && m_lvl[c]) begin
               m_age[c]++;
               if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0)) m_prs[c] = 1'b1;
            end
         end
         for (int j = S; j >= 1; j--) hist[j] = hist[j-1];
         hist[0] = btn;
      end
   end

   always @(posedge clk) begin
      #1;
      check("model", {btn_level, btn_press, btn_release}, {m_lvl, m_prs, m_rel});
   end

   typedef struct packed {
      logic        rst;
      logic [1:0]  btn;
      int unsigned n;
      logic [1:0]  lvl;
      logic [1:0]  prs;
      logic [1:0]  rel;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst = 1'b1;
      btn = 2'b11;

      // reset
      tbl.push_back('{1'b1, 2'b11, 2, 2'b00, 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b00, 3, 2'b00, 2'b00, 2'b00});
      // clean press on ch0, press at 6th edge
      tbl.push_back('{1'b0, 2'b01, 5, 2'b00, 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b01, 2'b00});
      tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b01, 13, 2'b01, AR ? 2'b01 : 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b00, 6, 2'b00, 2'b00, 2'b01});
      tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b00});
      // bounce 1,1,1,0 repeating
      for (int r = 0; r < 3; r++) begin
         tbl.push_back('{1'b0, 2'b01, 3, 2'b00, 2'b00, 2'b00});
         tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b00});
      end
      tbl.push_back('{1'b0, 2'b01, 5, 2'b00, 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b01, 2'b00});
      tbl.push_back('{1'b0, 2'b01, 1, 2'b01, 2'b00, 2'b00});
      // ch1 press, then simultaneous release
      tbl.push_back('{1'b0, 2'b11, 6, 2'b11, 2'b10, 2'b00});
      tbl.push_back('{1'b0, 2'b11, 1, 2'b11, AR ? 2'b01 : 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b00, 6, 2'b00, 2'b00, 2'b11});
      tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b00});
      // reset mid-count on ch1
      tbl.push_back('{1'b0, 2'b10, 3, 2'b00, 2'b00, 2'b00});
      tbl.push_back('{1'b1, 2'b10, 1, 2'b00, 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b10, 5, 2'b00, 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b10, 1, 2'b10, 2'b10, 2'b00});
      tbl.push_back('{1'b0, 2'b10, 1, 2'b10, 2'b00, 2'b00});
      tbl.push_back('{1'b0, 2'b00, 6, 2'b00, 2'b00, 2'b10});
      tbl.push_back('{1'b0, 2'b00, 1, 2'b00, 2'b00, 2'b00});

      @(negedge clk);
      foreach (tbl[k]) begin
         rst = tbl[k].rst;
         btn = tbl[k].btn;
         repeat (tbl[k].n) @(posedge clk);
         @(negedge clk);
         check($sformatf("step%0d", k), {btn_level, btn_press, btn_release},
               {tbl[k].lvl, tbl[k].prs, tbl[k].rel});
      end

`ifdef DEBOUNCE_AUTOREPEAT_EN
      // press ch0, hold, release so that it is accepted 18 edges after the press
      btn = 2'b01;
      repeat (S + 2) @(posedge clk);
      @(negedge clk);
      check("ar_press", {btn_level, btn_press, btn_release}, 6'b01_01_00);
      for (int k = 1; k <= 30; k++) begin
         logic [1:0] ep;
         logic [1:0] el;
         logic [1:0] er;
         @(posedge clk);
         @(negedge clk);
         ep = (k == 8 || k == 11 || k == 14 || k == 17) ? 2'b01 : 2'b00;
         el = (k < 18) ? 2'b01 : 2'b00;
         er = (k == 18) ? 2'b01 : 2'b00;
         check($sformatf("ar_k%0d", k), {btn_level, btn_press, btn_release}, {el, ep, er});
         if (k == 12) btn = 2'b00;
      end
`endif

      // random stimulus, checked every cycle by the model
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < 2; c++) if ($urandom_range(9) == 0) btn[c] = ~btn[c];
         rst = ($urandom_range(599) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
